acceso_ctrl: RTL
================

Name: acceso_ctrl

Overview:
- Access sequencer between the UART/RFID receive path, the keypad, the door motors and the LCD message selector.
- Accepts an RFID tag as a UART byte stream, then a 4-digit keypad PIN, and checks both against parameters.
- On a match it runs a motor open/hold/close cycle with sensor feedback. On a mismatch it counts failures and locks out after MAX_FAIL failures.
- It is the cycle-accurate replacement for the 1 Hz state machine and runs on the 50 MHz system clock.

Parameters:
- TAG_LEN, 4: number of tag bytes per RFID frame (1..8).
- AUTH_TAG, 64'h0000_0000_1A2B_3C4D: authorised tag. Bytes are compared MSB-first; only the low 8*TAG_LEN bits are used.
- AUTH_PIN, 16'h1234: authorised PIN, 4 BCD digits, first key in [15:12].
- TIMEOUT_CYC, 500_000_000: idle limit between tag bytes and between keys.
- MOVE_CYC, 150_000_000: maximum motor run time per direction before fault.
- HOLD_CYC, 250_000_000: time the door is held open.
- LOCK_CYC, 1_500_000_000: lockout duration.
- MAX_FAIL, 3: consecutive failures that trigger lockout.

Ports:
- clk, in, 1: system clock.
- Rst, in, 1: synchronous, active-high reset.
- RxDone, in, 1: one-cycle strobe; RxData is valid in that cycle.
- RxData, in, 8: received UART byte.
- key_valid, in, 1: one-cycle strobe on a debounced key press.
- key_num, in, 4: key code; 0-9 are digits, A-F are function keys.
- sens, in, 2: sens[0] = door fully open, sens[1] = door fully closed (both active-high).
- mot, out, 2: 2'b01 = open, 2'b10 = close, 2'b00 = stop; 2'b11 never driven.
- msg, out, 4: LCD message code. 0 idle, 1 reading tag, 2 enter PIN, 3 granted/opening, 4 door open, 5 closing, 6 denied, 7 locked, 8 fault.
- digits, out, 3: PIN digits entered so far (0..4).
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, mot=00, msg=0, digits=0, busy=0, fail_cnt=0, all timers and the tag shift register cleared. Reset overrides everything, including mid-motion; the motors stop on the next edge.
- Every output is registered. A state change is visible one cycle after the causing strobe.

States and transitions:
- IDLE: an RxDone strobe loads the byte into the tag shift register, sets byte_cnt=1 and goes to TAG.
  - If TAG_LEN=1, go straight to PIN instead.
  - key_valid is ignored in IDLE.
- TAG: each RxDone shifts in a byte and increments byte_cnt. When byte_cnt reaches TAG_LEN, latch tag_ok = (shift register == AUTH_TAG[8*TAG_LEN-1:0]) and go to PIN.
  - The inter-byte timer reloads on each byte; expiry at TIMEOUT_CYC returns to IDLE with no failure counted.
- PIN: each key_valid with key_num<=9 appends the digit and increments digits.
  - key_num A-F: see Optional Feature.
  - When the 4th digit is accepted, go to CHECK.
  - The inter-key timer reloads on each accepted key; expiry counts as a failure and goes to DENY.
  - RxDone is ignored in PIN.
- CHECK (1 cycle): if tag_ok and PIN==AUTH_PIN, clear fail_cnt and go to OPEN. Otherwise increment fail_cnt (saturating) and go to DENY.
- OPEN: mot=01 until sens[0]=1, then go to HOLD.
  - If MOVE_CYC elapses first, go to FAULT.
  - If sens[0] is already 1 on entry, move to HOLD after one cycle.
- HOLD: mot=00 for HOLD_CYC cycles, then go to CLOSE.
- CLOSE: mot=10 until sens[1]=1, then go to IDLE. If MOVE_CYC elapses first, go to FAULT.
- DENY: show msg=6 for HOLD_CYC cycles. Then go to LOCK if fail_cnt>=MAX_FAIL, else IDLE.
- LOCK: all inputs ignored for LOCK_CYC cycles. Then clear fail_cnt and go to IDLE.
- FAULT: mot=00, msg=8. Exited only by Rst.

Other rules:
- sens=2'b11 (both sensors active) while in OPEN or CLOSE is a fault: go to FAULT on the next edge.
- If RxDone and key_valid arrive in the same cycle, each is used only if the current state accepts it; there is no queueing.
- digits is cleared on every entry to IDLE, DENY and LOCK.
- Timer widths are $clog2 of the largest cycle parameter. Timers are down-counters reloaded on each state entry.

Optional Feature:
- Macro: ACC_KEYCLR_EN.
- Defined: in PIN, key 4'hA clears the entered digits (digits=0) and reloads the inter-key timer; key 4'hB aborts to IDLE with no failure counted.
- Undefined: keys A-F in PIN are ignored and do not reload the timer.

Test Plan:
- Bench parameters: TAG_LEN=4, TIMEOUT_CYC=100, MOVE_CYC=50, HOLD_CYC=20, LOCK_CYC=200.
- Correct access: bytes 1A,2B,3C,4D then keys 1,2,3,4; sens[0]=1 at +10 cycles, sens[1]=1 at +10 cycles into CLOSE -> mot 01, then 00 for 20 cycles, then 10, then IDLE with msg=0; fail_cnt=0.
- Wrong tag: bytes 1A,2B,3C,4E then PIN 1234 -> CHECK goes to DENY, msg=6 for 20 cycles, then IDLE; mot stays 00.
- Lockout: three wrong PINs (1235) after a correct tag -> third DENY goes to LOCK, msg=7 for 200 cycles, RxDone ignored throughout, then IDLE.
- Timeouts: two tag bytes then silence for 100 cycles -> IDLE, fail_cnt unchanged. After the tag, key 1 then silence for 100 cycles -> DENY, fail_cnt=1.
- Motor fault: grant access with sens held 00 -> after 50 cycles, FAULT, mot=00, msg=8; only Rst recovers. Rst asserted mid-OPEN -> mot=00 on the next edge.
- Key clear (ACC_KEYCLR_EN defined): keys 1,9,A,1,2,3,4 -> digits goes 2->0, access granted. With the macro undefined, the same sequence -> CHECK sees PIN 1912 and goes to DENY.

Source files
------------

// File: rtl/acceso_ctrl.sv
`timescale 1ns/1ps
// acceso_ctrl: door access sequencer. It takes an RFID tag as a UART byte
// stream, then a 4-digit keypad PIN, checks both against the authorised
// values and runs the door motor open/hold/close cycle with sensor feedback.
// Repeated failures lock the unit out for a while.
//
// Optional feature macro: ACC_KEYCLR_EN
//   defined   : key A clears the entered PIN digits, key B aborts to idle
//   undefined : keys A-F are ignored while entering the PIN
//
// Ports:
//   clk       in   system clock
//   Rst       in   synchronous active-high reset
//   RxDone    in   one-cycle strobe, RxData valid
//   RxData    in   received UART byte
//   key_valid in   one-cycle strobe on a debounced key press
//   key_num   in   key code (0-9 digits, A-F function keys)
//   sens      in   [0] door fully open, [1] door fully closed
//   mot       out  01 open, 10 close, 00 stop
//   msg       out  LCD message code
//   digits    out  PIN digits entered so far
//   busy      out  high whenever the sequencer is not idle
module acceso_ctrl #(
  parameter int unsigned TAG_LEN     = 4,
  parameter logic [63:0] AUTH_TAG    = 64'h0000_0000_1A2B_3C4D,
  parameter logic [15:0] AUTH_PIN    = 16'h1234,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned MOVE_CYC    = 150_000_000,
  parameter int unsigned HOLD_CYC    = 250_000_000,
  parameter int unsigned LOCK_CYC    = 1_500_000_000,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       RxDone,
  input  logic [7:0] RxData,
  input  logic       key_valid,
  input  logic [3:0] key_num,
  input  logic [1:0] sens,
  output logic [1:0] mot,
  output logic [3:0] msg,
  output logic [2:0] digits,
  output logic       busy
);

  localparam int unsigned TAG_W   = 8 * TAG_LEN;
  localparam int unsigned CNT_W   = $clog2(TAG_LEN + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned MAX_A   = (TIMEOUT_CYC > MOVE_CYC) ? TIMEOUT_CYC : MOVE_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > LOCK_CYC) ? HOLD_CYC : LOCK_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Timers count down from CYC-1 so a state lasts exactly CYC cycles.
  localparam logic [TMR_W-1:0] TMO_LD  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] MOVE_LD = TMR_W'(MOVE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TAG, S_PIN, S_CHECK, S_OPEN, S_HOLD, S_CLOSE, S_DENY, S_LOCK, S_FAULT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [TAG_W-1:0]  r_tag, w_tag_nxt, w_tag_in;
  logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic              r_tag_ok, w_tag_ok_nxt, w_tag_match;
  logic [15:0]       r_pin, w_pin_nxt;
  logic [2:0]        r_digits, w_digits_nxt;
  logic [FAIL_W-1:0] r_fail_cnt, w_fail_nxt, w_fail_inc;
  logic [1:0]        r_mot, w_mot_nxt;
  logic [3:0]        r_msg, w_msg_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_digit_key;

  // First byte of a frame loads into an empty register, later bytes shift in.
  assign w_tag_in    = (r_state == S_IDLE) ? TAG_W'(RxData) : ((r_tag << 8) | TAG_W'(RxData));
  assign w_tag_match = (w_tag_in == AUTH_TAG[TAG_W-1:0]);
  assign w_fail_inc  = (r_fail_cnt < FAIL_W'(MAX_FAIL)) ? r_fail_cnt + FAIL_W'(1) : r_fail_cnt;
  assign w_digit_key = key_valid && (key_num <= 4'd9);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_tag      <= '0;
      r_byte_cnt <= '0;
      r_tag_ok   <= 1'b0;
      r_pin      <= '0;
      r_digits   <= '0;
      r_fail_cnt <= '0;
      r_mot      <= 2'b00;
      r_msg      <= 4'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_tag      <= w_tag_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tag_ok   <= w_tag_ok_nxt;
      r_pin      <= w_pin_nxt;
      r_digits   <= w_digits_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_mot      <= w_mot_nxt;
      r_msg      <= w_msg_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state, datapath updates and outputs decoded from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = (r_tmr != '0) ? r_tmr - TMR_W'(1) : r_tmr;
    w_tag_nxt      = r_tag;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tag_ok_nxt   = r_tag_ok;
    w_pin_nxt      = r_pin;
    w_digits_nxt   = r_digits;
    w_fail_nxt     = r_fail_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (RxDone) begin
          w_tag_nxt      = w_tag_in;
          w_byte_cnt_nxt = CNT_W'(1);
          w_tmr_nxt      = TMO_LD;
          if (TAG_LEN == 1) begin
            w_tag_ok_nxt = w_tag_match;
            w_state_nxt  = S_PIN;
          end else begin
            w_state_nxt  = S_TAG;
          end
        end
      end
      S_TAG: begin
        if (RxDone) begin
          w_tag_nxt      = w_tag_in;
          w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
          w_tmr_nxt      = TMO_LD;
          if (r_byte_cnt + CNT_W'(1) == CNT_W'(TAG_LEN)) begin
            w_tag_ok_nxt = w_tag_match;
            w_state_nxt  = S_PIN;
          end
        end else if (r_tmr == '0) begin
          w_state_nxt  = S_IDLE;
          w_digits_nxt = '0;
        end
      end
      S_PIN: begin
        if (w_digit_key) begin
          w_pin_nxt    = {r_pin[11:0], key_num};
          w_digits_nxt = r_digits + 3'd1;
          w_tmr_nxt    = TMO_LD;
          if (r_digits == 3'd3) begin
            w_state_nxt = S_CHECK;
          end
        end
`ifdef ACC_KEYCLR_EN
        else if (key_valid && (key_num == 4'hA)) begin
          w_pin_nxt    = '0;
          w_digits_nxt = '0;
          w_tmr_nxt    = TMO_LD;
        end else if (key_valid && (key_num == 4'hB)) begin
          w_pin_nxt    = '0;
          w_digits_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
`endif
        else if (r_tmr == '0) begin
          w_fail_nxt   = w_fail_inc;
          w_digits_nxt = '0;
          w_tmr_nxt    = HOLD_LD;
          w_state_nxt  = S_DENY;
        end
      end
      S_CHECK: begin
        if (r_tag_ok && (r_pin == AUTH_PIN)) begin
          w_fail_nxt  = '0;
          w_tmr_nxt   = MOVE_LD;
          w_state_nxt = S_OPEN;
        end else begin
          w_fail_nxt   = w_fail_inc;
          w_digits_nxt = '0;
          w_tmr_nxt    = HOLD_LD;
          w_state_nxt  = S_DENY;
        end
      end
      S_OPEN: begin
        // Both limit switches active at once means a broken sensor.
        if (sens == 2'b11) begin
          w_state_nxt = S_FAULT;
        end else if (sens[0]) begin
          w_tmr_nxt   = HOLD_LD;
          w_state_nxt = S_HOLD;
        end else if (r_tmr == '0) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_HOLD: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = MOVE_LD;
          w_state_nxt = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (sens == 2'b11) begin
          w_state_nxt = S_FAULT;
        end else if (sens[1]) begin
          w_digits_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_DENY: begin
        if (r_tmr == '0) begin
          w_digits_nxt = '0;
          if (r_fail_cnt >= FAIL_W'(MAX_FAIL)) begin
            w_tmr_nxt   = LOCK_LD;
            w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        if (r_tmr == '0) begin
          w_fail_nxt   = '0;
          w_digits_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase

    w_mot_nxt  = 2'b00;
    w_msg_nxt  = 4'd0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    unique case (w_state_nxt)
      S_IDLE:  w_msg_nxt = 4'd0;
      S_TAG:   w_msg_nxt = 4'd1;
      S_PIN:   w_msg_nxt = 4'd2;
      S_CHECK: w_msg_nxt = 4'd2;
      S_OPEN:  begin w_msg_nxt = 4'd3; w_mot_nxt = 2'b01; end
      S_HOLD:  w_msg_nxt = 4'd4;
      S_CLOSE: begin w_msg_nxt = 4'd5; w_mot_nxt = 2'b10; end
      S_DENY:  w_msg_nxt = 4'd6;
      S_LOCK:  w_msg_nxt = 4'd7;
      S_FAULT: w_msg_nxt = 4'd8;
      default: w_msg_nxt = 4'd8;
    endcase
  end

  assign mot    = r_mot;
  assign msg    = r_msg;
  assign digits = r_digits;
  assign busy   = r_busy;

endmodule
